// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed hex 7-segment driver with registered outputs.
// Define HEX_LEADING_ZERO_SUPPRESS_EN to blank leading zero digits (digit 0 always shown).
module hex_display_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1024,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic [0:6]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [0:6] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic [4*DIGITS-1:0] shadow;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [3:0]          nib;
  logic                wrap, last, lit;
  assign nib  = shadow[4*idx +: 4];
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign last = idx == IW'(DIGITS - 1);
`ifdef HEX_LEADING_ZERO_SUPPRESS_EN
  logic [DIGITS-1:0] dark;
  logic              zeros;
  // A digit is dark when it and everything above it is zero; the loop stops before digit 0.
  always_comb begin
    zeros = 1'b1;
    dark  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zeros   = zeros & (shadow[4*i +: 4] == 4'd0);
      dark[i] = zeros;
    end
  end
  assign lit = int'(cnt) >= BLANK_CYCLES && !dark[idx];
`else
  assign lit = int'(cnt) >= BLANK_CYCLES;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      cnt        <= '0;
      idx        <= '0;
      segments   <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) shadow <= value;
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= last ? '0 : idx + 1'b1;
      segments   <= lit ? GLYPH[nib] : '0;
      digit_en   <= lit ? DIGITS'(1) << idx : '0;
      frame_done <= wrap && last;
    end
  end
endmodule
